// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster engine: pattern mode encodings,
// the eight-colour bar palette and standard timing presets.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT  = 2'd0,
        MODE_VBAR = 2'd1,
        MODE_HBAR = 2'd2,
        MODE_CHK  = 2'd3
    } vga_mode_t;

    typedef struct packed {
        int h_disp;
        int h_front;
        int h_sync;
        int h_back;
        int v_disp;
        int v_front;
        int v_sync;
        int v_back;
        bit h_pol;
        bit v_pol;
    } vga_timing_t;

    localparam vga_timing_t TIMING_640X480_60 = '{
        h_disp: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_disp: 480, v_front: 10, v_sync: 2, v_back: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_timing_t TIMING_800X600_60 = '{
        h_disp: 800, h_front: 40, h_sync: 128, h_back: 88,
        v_disp: 600, v_front: 1, v_sync: 4, v_back: 23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    localparam vga_timing_t TIMING_1280X1024_60 = '{
        h_disp: 1280, h_front: 48, h_sync: 112, h_back: 248,
        v_disp: 1024, v_front: 1, v_sync: 3, v_back: 38,
        h_pol: 1'b1, v_pol: 1'b1
    };

    // {R,G,B} on/off mask for bar colour idx, brightest first.
    function automatic logic [2:0] palette_mask(input logic [2:0] idx);
        logic [2:0] mask;
        case (idx)
            3'd0:    mask = 3'b111;
            3'd1:    mask = 3'b110;
            3'd2:    mask = 3'b011;
            3'd3:    mask = 3'b010;
            3'd4:    mask = 3'b101;
            3'd5:    mask = 3'b100;
            3'd6:    mask = 3'b001;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour source: bars and checkerboard computed from the requested
// pixel stream, registered so it lines up with externally returned pixel data.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_DISP   = 1280,
    parameter int V_DISP   = 1024,
    parameter int CW       = 4,
    parameter int CNT_W    = 11,
    parameter int NUM_BARS = 8,
    parameter int CHK_LOG2 = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [CNT_W-1:0] x,
    input  logic [CNT_W-1:0] y,
    input  logic             de,
    input  vga_mode_t        mode,
    output logic [3*CW-1:0]  rgb
);
    localparam logic [CNT_W-1:0] BAR_W_M1 = CNT_W'(H_DISP / NUM_BARS - 1);
    localparam logic [CNT_W-1:0] BAR_H_M1 = CNT_W'(V_DISP / NUM_BARS - 1);
    localparam logic [CNT_W-1:0] LAST_BAR = CNT_W'(NUM_BARS - 1);
    localparam logic [CNT_W-1:0] LAST_X   = CNT_W'(H_DISP - 1);
    localparam logic [CNT_W-1:0] LAST_Y   = CNT_W'(V_DISP - 1);

    logic [CNT_W-1:0] h_sub, h_bar, v_sub, v_bar;
    logic [2:0]       h_pal, v_pal;
    logic [2:0]       mask;

    // Sub-counters track the bar of the pixel currently presented, replacing a divider;
    // the last bar saturates so remainder pixels extend it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_sub <= '0;
            h_bar <= '0;
            h_pal <= '0;
            v_sub <= '0;
            v_bar <= '0;
            v_pal <= '0;
            rgb   <= '0;
        end else if (ce) begin
            if (!de || x == LAST_X) begin
                h_sub <= '0;
                h_bar <= '0;
                h_pal <= '0;
            end else if (h_sub != BAR_W_M1) begin
                h_sub <= h_sub + 1'b1;
            end else if (h_bar != LAST_BAR) begin
                h_sub <= '0;
                h_bar <= h_bar + 1'b1;
                h_pal <= h_pal + 3'd1;
            end
            if (de && x == LAST_X) begin
                if (y == LAST_Y) begin
                    v_sub <= '0;
                    v_bar <= '0;
                    v_pal <= '0;
                end else if (v_sub != BAR_H_M1) begin
                    v_sub <= v_sub + 1'b1;
                end else if (v_bar != LAST_BAR) begin
                    v_sub <= '0;
                    v_bar <= v_bar + 1'b1;
                    v_pal <= v_pal + 3'd1;
                end
            end
            rgb <= de ? {{CW{mask[2]}}, {CW{mask[1]}}, {CW{mask[0]}}} : '0;
        end
    end

    always_comb begin
        mask = 3'b000;
        case (mode)
            MODE_VBAR: mask = palette_mask(h_pal);
            MODE_HBAR: mask = palette_mask(v_pal);
            MODE_CHK:  mask = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? 3'b111 : 3'b000;
            default:   mask = 3'b000;
        endcase
    end

endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster engine: programmable H/V timing, pixel request/return pipeline and
// built-in test patterns, all advancing only on pixel-enable edges.
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int H_DISP   = TIMING_1280X1024_60.h_disp,
    parameter int H_FRONT  = TIMING_1280X1024_60.h_front,
    parameter int H_SYNC   = TIMING_1280X1024_60.h_sync,
    parameter int H_BACK   = TIMING_1280X1024_60.h_back,
    parameter int V_DISP   = TIMING_1280X1024_60.v_disp,
    parameter int V_FRONT  = TIMING_1280X1024_60.v_front,
    parameter int V_SYNC   = TIMING_1280X1024_60.v_sync,
    parameter int V_BACK   = TIMING_1280X1024_60.v_back,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int CW       = 4,
    parameter int CNT_W    = 11,
    parameter int NUM_BARS = 8,
    parameter int CHK_LOG2 = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PIX_CE,
    input  logic [1:0]       MODE,
    output logic             PIX_REQ,
    output logic [CNT_W-1:0] PIX_X,
    output logic [CNT_W-1:0] PIX_Y,
    input  logic [3*CW-1:0]  PIX_DATA,
    output logic             FRAME_START,
    output logic             VGA_HSYNC,
    output logic             VGA_VSYNC,
    output logic             VGA_DE,
    output logic [CW-1:0]    VGA_RED,
    output logic [CW-1:0]    VGA_GREEN,
    output logic [CW-1:0]    VGA_BLUE
);
    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISP + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISP + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISP + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISP + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] hcnt, vcnt;
    vga_mode_t        mode_q;
    logic             active, line_end, frame_origin, hs_region, vs_region;
    logic             hs1, vs1, de2, hs2, vs2, ext2;
    logic [3*CW-1:0]  pat_rgb;

    assign active       = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign line_end     = (hcnt == H_LAST);
    assign frame_origin = (hcnt == '0) && (vcnt == '0);
    assign hs_region    = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_region    = (vcnt >= VS_BEG) && (vcnt < VS_END);

    // Stage 1: raster counters, pixel request and frame-boundary mode capture.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hcnt        <= '0;
            vcnt        <= '0;
            mode_q      <= MODE_VBAR;
            PIX_REQ     <= 1'b0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            FRAME_START <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
        end else if (PIX_CE) begin
            hcnt <= line_end ? '0 : hcnt + 1'b1;
            if (line_end) begin
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end
            if (frame_origin) begin
                mode_q <= vga_mode_t'(MODE);
            end
            PIX_REQ     <= active;
            PIX_X       <= active ? hcnt : '0;
            PIX_Y       <= active ? vcnt : '0;
            FRAME_START <= frame_origin;
            hs1         <= hs_region;
            vs1         <= vs_region;
        end
    end

    // Stages 2 and 3: wait for the returned pixel, then drive the connector.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            de2       <= 1'b0;
            hs2       <= 1'b0;
            vs2       <= 1'b0;
            ext2      <= 1'b0;
            VGA_DE    <= 1'b0;
            VGA_HSYNC <= ~H_POL;
            VGA_VSYNC <= ~V_POL;
            {VGA_RED, VGA_GREEN, VGA_BLUE} <= '0;
        end else if (PIX_CE) begin
            de2       <= PIX_REQ;
            hs2       <= hs1;
            vs2       <= vs1;
            ext2      <= (mode_q == MODE_EXT);
            VGA_DE    <= de2;
            VGA_HSYNC <= hs2 ? H_POL : ~H_POL;
            VGA_VSYNC <= vs2 ? V_POL : ~V_POL;
            {VGA_RED, VGA_GREEN, VGA_BLUE} <= !de2 ? '0 : (ext2 ? PIX_DATA : pat_rgb);
        end
    end

    vga_pattern_gen #(
        .H_DISP  (H_DISP),
        .V_DISP  (V_DISP),
        .CW      (CW),
        .CNT_W   (CNT_W),
        .NUM_BARS(NUM_BARS),
        .CHK_LOG2(CHK_LOG2)
    ) u_pattern (
        .clk  (CLK),
        .rst_n(RST_N),
        .ce   (PIX_CE),
        .x    (PIX_X),
        .y    (PIX_Y),
        .de   (PIX_REQ),
        .mode (mode_q),
        .rgb  (pat_rgb)
    );

endmodule
